prefetch_buffer: RTL and testbench

PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

---
 rtl/prefetch_buffer.sv | 184 ++++++++++++++++++
 tb/tb_prefetch_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_buffer
// Description : Byte-granular instruction prefetch buffer. Reads whole RAM
//               words ahead of the consumer, splits them into bytes (offset 0
//               in the most significant byte), and presents them through a
//               small FIFO tagged with their byte program counter. A redirect
//               flushes the FIFO and any in-flight word and restarts fetch.
//               Optional feature macro: PREFETCH_FLUSH_COUNT_EN adds a 16-bit
//               flushCount output counting sampled redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_buffer #(
  parameter  int addrBits     = 8,
  parameter  int dataBits     = 16,
  parameter  int depth        = 4,
  localparam int bytesPerWord = dataBits / 8,
  localparam int c_OFS_BITS   = $clog2(bytesPerWord),
  localparam int pcBits       = addrBits + c_OFS_BITS
) (
  input  logic                clk,
  input  logic                reset,
  output logic [addrBits-1:0] programAddress,
  input  logic [dataBits-1:0] programDataOut,
  input  logic                redirect,
  input  logic [pcBits-1:0]   redirectPc,
  output logic [7:0]          instruction,
  output logic [pcBits-1:0]   instructionPc,
  output logic [pcBits-1:0]   nextProgramCounter,
  output logic                instructionValid,
  input  logic                instructionTake
`ifdef PREFETCH_FLUSH_COUNT_EN
  ,
  output logic [15:0]         flushCount
`endif
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int c_OFS_W = (c_OFS_BITS > 0) ? c_OFS_BITS : 1;
  localparam int c_PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int c_CNT_W = $clog2(depth + 1);
  localparam int c_SPC_W = c_CNT_W + 2;

  localparam logic [pcBits-1:0]  c_OFS_MASK  = pcBits'(bytesPerWord - 1);
  localparam logic [pcBits-1:0]  c_WORD_STEP = pcBits'(bytesPerWord);
  localparam logic [c_PTR_W-1:0] c_PTR_MASK  = c_PTR_W'(depth - 1);

  // RUN means a read was issued at the last edge, so a word is in flight.
  localparam logic [0:0] S_STALL = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]          r_state;
  logic [pcBits-1:0]   r_fetchPc;       // next word-aligned pc to issue
  logic [pcBits-1:0]   r_flightPc;      // pc of the word currently in flight
  logic [addrBits-1:0] r_programAddress;

  logic [7:0]          r_fifoData [depth];
  logic [pcBits-1:0]   r_fifoPc   [depth];
  logic [c_PTR_W-1:0]  r_rdPtr;
  logic [c_PTR_W-1:0]  r_wrPtr;
  logic [c_CNT_W-1:0]  r_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic               w_inFlight;
  logic               w_valid;
  logic               w_pop;
  logic [c_OFS_W-1:0] w_flightOfs;
  logic [c_CNT_W-1:0] w_enqBytes;
  logic [c_SPC_W-1:0] w_space;
  logic               w_issue;
  logic [pcBits-1:0]  w_issuePc;
  logic [7:0]         w_wordBytes [bytesPerWord];

  // Split the returned RAM word into bytes, offset 0 taken from the top.
  for (genvar g = 0; g < bytesPerWord; g++) begin : g_wordBytes
    assign w_wordBytes[g] = programDataOut[dataBits-1-8*g -: 8];
  end

  assign w_inFlight  = (r_state == S_RUN);
  assign w_valid     = (r_count != '0);
  // A redirect cycle ignores the consumer's take entirely.
  assign w_pop       = instructionTake & w_valid & ~redirect;
  assign w_flightOfs = c_OFS_W'(r_flightPc & c_OFS_MASK);

  // Bytes of the in-flight word that land in the FIFO at this edge.
  assign w_enqBytes  = w_inFlight
                     ? (c_CNT_W'(bytesPerWord) - c_CNT_W'(w_flightOfs))
                     : '0;

  // Free space after this edge, counting this cycle's pop and the arriving
  // word. Occupancy plus in-flight bytes never exceeds depth, so this cannot
  // go negative.
  assign w_space = c_SPC_W'(depth) + c_SPC_W'(w_pop)
                 - c_SPC_W'(r_count) - c_SPC_W'(w_enqBytes);

  // A redirect always issues its target word immediately.
  assign w_issue   = redirect | (w_space >= c_SPC_W'(bytesPerWord));
  assign w_issuePc = redirect ? redirectPc : r_fetchPc;

  // --------------------------------------------------------------------------
  // Fetch FSM: issue decision, RAM address and fetch program counter
  // --------------------------------------------------------------------------
  // Issue a word read whenever space allows, or unconditionally on redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_STALL;
      r_fetchPc        <= '0;
      r_flightPc       <= '0;
      r_programAddress <= '0;
    end else begin
      r_state <= w_issue ? S_RUN : S_STALL;
      if (w_issue) begin
        r_programAddress <= addrBits'(w_issuePc >> c_OFS_BITS);
        r_flightPc       <= w_issuePc;
        r_fetchPc        <= (w_issuePc & ~c_OFS_MASK) + c_WORD_STEP;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Instruction FIFO
  // --------------------------------------------------------------------------
  // Enqueue the in-flight word's bytes and pop the head; flush on redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        r_fifoData[i] <= '0;
        r_fifoPc[i]   <= '0;
      end
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < bytesPerWord; i++) begin
        if (c_CNT_W'(i) < w_enqBytes) begin
          r_fifoData[(r_wrPtr + c_PTR_W'(i)) & c_PTR_MASK] <=
            w_wordBytes[c_OFS_W'(w_flightOfs + c_OFS_W'(i))];
          r_fifoPc[(r_wrPtr + c_PTR_W'(i)) & c_PTR_MASK] <=
            r_flightPc + pcBits'(i);
        end
      end
      r_wrPtr <= (r_wrPtr + c_PTR_W'(w_enqBytes)) & c_PTR_MASK;
      r_rdPtr <= (r_rdPtr + c_PTR_W'(w_pop)) & c_PTR_MASK;
      r_count <= r_count + w_enqBytes - c_CNT_W'(w_pop);
    end
  end

`ifdef PREFETCH_FLUSH_COUNT_EN
  logic [15:0] r_flushCount;

  // Count every sampled redirect, wrapping at 2^16.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flushCount <= '0;
    end else if (redirect) begin
      r_flushCount <= r_flushCount + 16'd1;
    end
  end

  assign flushCount = r_flushCount;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign programAddress     = r_programAddress;
  assign instruction        = r_fifoData[r_rdPtr];
  assign instructionPc      = r_fifoPc[r_rdPtr];
  assign nextProgramCounter = r_fifoPc[r_rdPtr] + pcBits'(1);
  assign instructionValid   = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefetch_buffer
// Description : Self-checking bench for prefetch_buffer (addrBits=8,
//               dataBits=16, depth=4). RAM byte at address a holds a mod 256.
//               Directed scenarios followed by randomized traffic, checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefetch_buffer;

  localparam int c_PC_MOD = 512;
  localparam int c_BPW    = 2;
  localparam int c_DEPTH  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] programAddress;
  logic [15:0] programDataOut;
  logic       redirect;
  logic [8:0] redirectPc;
  logic [7:0] instruction;
  logic [8:0] instructionPc;
  logic [8:0] nextProgramCounter;
  logic       instructionValid;
  logic       instructionTake;
`ifdef PREFETCH_FLUSH_COUNT_EN
  logic [15:0] flushCount;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_q[$];
  bit m_inflight;
  int m_flightPc;
  int m_fetch;
  int m_addr;
  int m_flush;

  always #5 clk = ~clk;

  // RAM: word a holds bytes 2a and 2a+1 (mod 256), offset 0 in the top byte.
  assign programDataOut = {programAddress[6:0], 1'b0, programAddress[6:0], 1'b1};

  prefetch_buffer #(.addrBits(8), .dataBits(16), .depth(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .programAddress     (programAddress),
    .programDataOut     (programDataOut),
    .redirect           (redirect),
    .redirectPc         (redirectPc),
    .instruction        (instruction),
    .instructionPc      (instructionPc),
    .nextProgramCounter (nextProgramCounter),
    .instructionValid   (instructionValid),
    .instructionTake    (instructionTake)
`ifdef PREFETCH_FLUSH_COUNT_EN
    ,
    .flushCount         (flushCount)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inflight = 1'b0;
    m_flightPc = 0;
    m_fetch    = 0;
    m_addr     = 0;
    m_flush    = 0;
  endtask

  // One clock edge of the specified behaviour, in queue terms.
  task automatic model_edge(input bit r, input int rp, input bit t);
    int pop, nenq, space, wend;
    if (r) begin
      m_q.delete();
      m_inflight = 1'b1;
      m_flightPc = rp;
      m_addr     = rp / c_BPW;
      m_fetch    = ((rp / c_BPW) * c_BPW + c_BPW) % c_PC_MOD;
      m_flush    = (m_flush + 1) % 65536;
    end else begin
      pop   = (t && m_q.size() != 0) ? 1 : 0;
      nenq  = m_inflight ? (c_BPW - (m_flightPc % c_BPW)) : 0;
      space = c_DEPTH - m_q.size() - nenq + pop;
      if (pop != 0) void'(m_q.pop_front());
      if (m_inflight) begin
        wend = (m_flightPc / c_BPW) * c_BPW + c_BPW;
        for (int b = m_flightPc; b < wend; b++) m_q.push_back(b);
      end
      m_inflight = (space >= c_BPW);
      if (m_inflight) begin
        m_addr     = m_fetch / c_BPW;
        m_flightPc = m_fetch;
        m_fetch    = (m_fetch + c_BPW) % c_PC_MOD;
      end
    end
  endtask

  task automatic compare_model();
    chk("addr", programAddress, m_addr);
    chk("valid", instructionValid, (m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("instr", instruction, m_q[0] % 256);
      chk("pc", instructionPc, m_q[0]);
      chk("next", nextProgramCounter, (m_q[0] + 1) % c_PC_MOD);
    end
`ifdef PREFETCH_FLUSH_COUNT_EN
    chk("flush", flushCount, m_flush);
`endif
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit r, input int rp, input bit t);
    redirect        = r;
    redirectPc      = 9'(rp);
    instructionTake = t;
    @(posedge clk);
    model_edge(r, rp, t);
    @(negedge clk);
    compare_model();
  endtask

  task automatic expect_head(input int pc);
    chk("head_valid", instructionValid, 1);
    chk("head_instr", instruction, pc % 256);
    chk("head_pc", instructionPc, pc);
    chk("head_next", nextProgramCounter, (pc + 1) % c_PC_MOD);
  endtask

  task automatic check_reset_outputs();
    chk("rst_addr", programAddress, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", instructionPc, 0);
    chk("rst_next", nextProgramCounter, 1);
    chk("rst_valid", instructionValid, 0);
`ifdef PREFETCH_FLUSH_COUNT_EN
    chk("rst_flush", flushCount, 0);
`endif
  endtask

  // Called at a negedge: drop reset mid-cycle, check, release next negedge.
  task automatic do_reset();
    #1;
    reset           = 1'b0;
    redirect        = 1'b0;
    instructionTake = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset           = 1'b0;
    redirect        = 1'b0;
    redirectPc      = '0;
    instructionTake = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();

    // Release with take held high: 00,01,02,03 back to back
    instructionTake = 1'b1;
    reset           = 1'b1;
    cycle(1'b0, 0, 1'b1);
    chk("first_edge_valid", instructionValid, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 0, 1'b1);
      expect_head(k);
    end

    // Take low for 10 cycles: FIFO full, address frozen at word 1
    do_reset();
    repeat (10) cycle(1'b0, 0, 1'b0);
    chk("stall_addr", programAddress, 1);
    expect_head(0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, 0, 1'b1);
      expect_head(k);
    end

    // Redirect to 0x0E mid-stream
    cycle(1'b1, 'h00E, 1'b1);
    chk("redir0e_gap", instructionValid, 0);
    cycle(1'b0, 0, 1'b1);
    expect_head('h00E);
    cycle(1'b0, 0, 1'b1);
    expect_head('h00F);
    cycle(1'b0, 0, 1'b1);
    expect_head('h010);

    // Redirect to odd 0x0F with take high in the redirect cycle
    cycle(1'b1, 'h00F, 1'b1);
    chk("redir0f_gap", instructionValid, 0);
    cycle(1'b0, 0, 1'b1);
    expect_head('h00F);
    cycle(1'b0, 0, 1'b1);
    expect_head('h010);

    // Redirect to 0x1FF: wrap to 0x000
    cycle(1'b1, 'h1FF, 1'b1);
    cycle(1'b0, 0, 1'b1);
    expect_head('h1FF);
    cycle(1'b0, 0, 1'b1);
    expect_head('h000);

    // Reset mid-stream, then three redirects
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b1);
    do_reset();
    repeat (3) cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 'h040, 1'b1);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 'h123, 1'b0);
    cycle(1'b1, 'h1FE, 1'b1);
    cycle(1'b0, 0, 1'b1);
    expect_head('h1FE);
`ifdef PREFETCH_FLUSH_COUNT_EN
    chk("flush_three", flushCount, 3);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit r, t;
      int rp;
      r  = ($urandom_range(0, 99) < 5);
      t  = ($urandom_range(0, 99) < 65);
      rp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(500, 511))
                                       : int'($urandom_range(0, 511));
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle(r, rp, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
